// File: rtl/alu_seq_ctrl.sv
// Three-state sequencer (IDLE/EXEC/WB) that feeds an external combinational ALU
// from a 4-entry register file and writes the captured result back.
module alu_seq_ctrl #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
    output logic              done,
    output logic              err,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    localparam logic [2:0] OpLdi = 3'b101;

    state_e              state_q, state_d;
    logic [2:0]          op_q;
    logic [1:0]          rd_q;
    logic [7:0]          imm_q;
    logic [DATA_W-1:0]   cap_out_q;
    logic                cap_zero_q;
    logic [DATA_W-1:0]   rf_q [4];

    logic [2:0] in_op;
    logic [1:0] in_rd, in_rs;
    logic       accept;
    logic       op_is_alu, op_is_ldi, op_is_illegal;

    assign in_op  = instr[15:13];
    assign in_rd  = instr[12:11];
    assign in_rs  = instr[10:9];
    assign accept = instr_valid && instr_ready;

    assign op_is_alu     = (op_q <= 3'd4);
    assign op_is_ldi     = (op_q == OpLdi);
    assign op_is_illegal = (op_q[2:1] == 2'b11);

    assign dbg_data = rf_q[dbg_addr];

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = StExec;
            end
            StExec:  state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            cap_out_q  <= '0;
            cap_zero_q <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            result     <= '0;
            zero_flag  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            // Pulses are registered so they are high exactly during the WB cycle.
            done    <= (state_q == StExec);
            err     <= (state_q == StExec) && op_is_illegal;

            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                imm_q <= instr[7:0];
                if (in_op <= 3'd4) begin
                    alu_a   <= rf_q[in_rd];
                    alu_b   <= rf_q[in_rs];
                    alu_sel <= in_op;
                end
            end

            if (state_q == StExec) begin
                cap_out_q  <= alu_out;
                cap_zero_q <= alu_zero;
            end

            if (state_q == StWb) begin
                if (op_is_alu) begin
                    rf_q[rd_q] <= cap_out_q;
                    result     <= cap_out_q;
                    zero_flag  <= cap_zero_q;
                end else if (op_is_ldi) begin
                    rf_q[rd_q] <= DATA_W'(imm_q);
                    result     <= DATA_W'(imm_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a stub ALU driven from the stimulus sequence.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_zero;
    logic [7:0]  result;
    logic        zero_flag, done, err;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq_ctrl #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .result     (result),
        .zero_flag  (zero_flag),
        .done       (done),
        .err        (err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 1'b0, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction from IDLE; returns 1ns after the accepting edge (EXEC cycle).
    task automatic issue(input logic [15:0] w);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        alu_out     = 8'h00;
        alu_zero    = 1'b0;
        dbg_addr    = 2'd0;

        // Reset values
        #2;
        chk("rst_ready", {31'd0, instr_ready}, 1);
        chk("rst_alu_a", {24'd0, alu_a}, 0);
        chk("rst_alu_b", {24'd0, alu_b}, 0);
        chk("rst_alu_sel", {29'd0, alu_sel}, 0);
        chk("rst_result", {24'd0, result}, 0);
        chk("rst_zero", {31'd0, zero_flag}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        for (int i = 0; i < 4; i++) chk_reg("rst_rf", 2'(i), 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // LDI R1,0x0F
        issue(mk(3'b101, 2'd1, 2'd0, 8'h0F));
        chk("ldi_exec_ready", {31'd0, instr_ready}, 0);
        chk("ldi_exec_done", {31'd0, done}, 0);
        chk("ldi_alu_a_kept", {24'd0, alu_a}, 0);
        tick();
        chk("ldi_wb_done", {31'd0, done}, 1);
        chk("ldi_wb_err", {31'd0, err}, 0);
        chk("ldi_wb_ready", {31'd0, instr_ready}, 0);
        tick();
        chk("ldi_done_low", {31'd0, done}, 0);
        chk("ldi_result", {24'd0, result}, 8'h0F);
        chk("ldi_zero", {31'd0, zero_flag}, 0);
        chk("ldi_ready", {31'd0, instr_ready}, 1);
        chk_reg("ldi_r1", 2'd1, 8'h0F);

        // ALU sequencing with stub returning 0x5A
        issue(mk(3'b101, 2'd0, 2'd0, 8'hAA)); tick(); tick();
        issue(mk(3'b101, 2'd2, 2'd0, 8'hBB)); tick(); tick();
        alu_out  = 8'h5A;
        alu_zero = 1'b0;
        issue(mk(3'b011, 2'd0, 2'd2, 8'h00));
        chk("alu_a", {24'd0, alu_a}, 8'hAA);
        chk("alu_b", {24'd0, alu_b}, 8'hBB);
        chk("alu_sel", {29'd0, alu_sel}, 3'b011);
        tick();
        alu_zero = 1'b1;  // glitch outside EXEC must be ignored
        chk("alu_wb_done", {31'd0, done}, 1);
        tick();
        alu_zero = 1'b0;
        chk("alu_result", {24'd0, result}, 8'h5A);
        chk("alu_zero_ignored", {31'd0, zero_flag}, 0);
        chk_reg("alu_r0", 2'd0, 8'h5A);
        chk_reg("alu_r2_kept", 2'd2, 8'hBB);

        // Zero flag: op 001 rd=3 rs=3, stub returns 0 with zero=1
        alu_out  = 8'h00;
        alu_zero = 1'b1;
        issue(mk(3'b001, 2'd3, 2'd3, 8'h00));
        chk("z_alu_a", {24'd0, alu_a}, 8'h00);
        chk("z_alu_sel", {29'd0, alu_sel}, 3'b001);
        tick();
        alu_zero = 1'b0;
        tick();
        chk("z_flag", {31'd0, zero_flag}, 1);
        chk("z_result", {24'd0, result}, 8'h00);
        chk_reg("z_r3", 2'd3, 8'h00);
        issue(mk(3'b101, 2'd2, 2'd0, 8'h33)); tick(); tick();
        chk("ldi_keeps_zero", {31'd0, zero_flag}, 1);
        chk("ldi2_result", {24'd0, result}, 8'h33);

        // Illegal op 111
        issue(mk(3'b111, 2'd1, 2'd0, 8'h77));
        chk("ill_exec_ready", {31'd0, instr_ready}, 0);
        tick();
        chk("ill_done", {31'd0, done}, 1);
        chk("ill_err", {31'd0, err}, 1);
        chk("ill_wb_ready", {31'd0, instr_ready}, 0);
        tick();
        chk("ill_err_low", {31'd0, err}, 0);
        chk("ill_ready", {31'd0, instr_ready}, 1);
        chk("ill_result", {24'd0, result}, 8'h33);
        chk("ill_zero", {31'd0, zero_flag}, 1);
        chk("ill_alu_sel_kept", {29'd0, alu_sel}, 3'b001);
        chk_reg("ill_r1", 2'd1, 8'h0F);

        // Back-to-back: valid held high across two instructions
        instr       = mk(3'b101, 2'd0, 2'd0, 8'h11);
        instr_valid = 1'b1;
        tick();
        instr = mk(3'b101, 2'd3, 2'd0, 8'h22);
        chk("b2b_e1_ready", {31'd0, instr_ready}, 0);
        tick();
        chk("b2b_e2_done", {31'd0, done}, 1);
        tick();
        chk("b2b_e3_done", {31'd0, done}, 0);
        chk("b2b_e3_ready", {31'd0, instr_ready}, 1);
        chk_reg("b2b_r0", 2'd0, 8'h11);
        chk_reg("b2b_r3_not_yet", 2'd3, 8'h00);
        tick();
        instr_valid = 1'b0;
        chk("b2b_e4_ready", {31'd0, instr_ready}, 0);
        chk("b2b_e4_done", {31'd0, done}, 0);
        tick();
        chk("b2b_e5_done", {31'd0, done}, 1);
        tick();
        chk("b2b_e6_done", {31'd0, done}, 0);
        chk("b2b_e6_ready", {31'd0, instr_ready}, 1);
        chk_reg("b2b_r3", 2'd3, 8'h22);
        chk_reg("b2b_r0_kept", 2'd0, 8'h11);

        // Reset during EXEC
        alu_out = 8'hEE;
        issue(mk(3'b000, 2'd1, 2'd1, 8'h00));
        chk("rx_alu_a", {24'd0, alu_a}, 8'h0F);
        rst_n = 1'b0;
        #1;
        chk("rx_done", {31'd0, done}, 0);
        chk("rx_ready", {31'd0, instr_ready}, 1);
        chk("rx_alu_a_rst", {24'd0, alu_a}, 0);
        chk("rx_alu_sel_rst", {29'd0, alu_sel}, 0);
        chk("rx_result", {24'd0, result}, 0);
        chk("rx_zero", {31'd0, zero_flag}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rx_no_done", {31'd0, done}, 0);
        end
        chk_reg("rx_r1", 2'd1, 8'h00);
        chk("rx_result_after", {24'd0, result}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
